// File: rtl/result_uart_reporter_pkg.sv
// Shared definitions for the result UART reporter: FSM states, ASCII
// message constants, message lengths and the double-dabble helpers.
package result_uart_reporter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_Y     = 8'h59;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_N     = 8'h4E;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int MSG_LEN_MATCH = 13;
  localparam int MSG_LEN_NONE  = 6;

  // Both coordinates are converted as 10-bit binary into 4 BCD digits.
  localparam int BIN_W     = 10;
  localparam int BCD_W     = 16;
  localparam int DD_CYCLES = 10;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // ASCII character for one BCD digit.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/result_uart_reporter_if.sv
// Matcher result bus: the matcher drives it, the reporter consumes it.
interface result_uart_reporter_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  import result_uart_reporter_pkg::*;

  logic           valid_in;
  logic           match_in;
  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;

  modport master (output valid_in, match_in, x_in, y_in);
  modport slave  (input  valid_in, match_in, x_in, y_in);

endinterface

// File: rtl/result_uart_reporter_uart_tx.sv
// 8N1 UART byte transmitter: latches a byte on start, sends start bit,
// 8 data bits LSB first and a stop bit, each BAUD_DIV cycles long.
module uart_tx_byte #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TxD,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] baudCnt_q;
  logic [3:0]       bitCnt_q;
  logic [8:0]       shift_q;
  logic             txd_q;
  logic             busy_q;
  logic             bitEnd;

  assign bitEnd = busy_q && (baudCnt_q == BAUD_LAST);
  assign done   = bitEnd && (bitCnt_q == 4'd9);
  assign TxD    = txd_q;
  assign busy   = busy_q;

  // Baud and bit counters; the shift register holds the remaining data bits plus the stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '1;
    end else if (!busy_q) begin
      if (start) begin
        busy_q    <= 1'b1;
        txd_q     <= 1'b0;
        shift_q   <= {1'b1, data};
        baudCnt_q <= '0;
        bitCnt_q  <= '0;
      end
    end else if (bitEnd) begin
      baudCnt_q <= '0;
      if (bitCnt_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        bitCnt_q <= bitCnt_q + 4'd1;
        txd_q    <= shift_q[0];
        shift_q  <= {1'b1, shift_q[8:1]};
      end
    end else begin
      baudCnt_q <= baudCnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/result_uart_reporter.sv
// Turns each matcher result into an ASCII line on the UART: "Xdddd,Ydddd\r\n"
// for a match, "NONE\r\n" otherwise, then pulses sent_o as the send-complete.
module result_uart_reporter
  import result_uart_reporter_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  result_uart_reporter_if.slave res,
  output logic                  TxD,
  output logic                  busy_o,
  output logic                  sent_o
);

  localparam logic [3:0] DD_LAST = 4'(DD_CYCLES - 1);

  state_t           state_q, state_d;
  logic             valid_q;
  logic             match_q, match_d;
  logic [BIN_W-1:0] xBin_q, xBin_d, yBin_q, yBin_d;
  logic [BCD_W-1:0] xBcd_q, xBcd_d, yBcd_q, yBcd_d;
  logic [BCD_W-1:0] xAdj, yAdj;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       lastIdx;
  logic [X_W-1:0]   xIn;
  logic [Y_W-1:0]   yIn;
  logic             trigger;
  logic             txStart, txBusy, txDone;
  logic [7:0]       txByte;

  assign xIn     = res.x_in;
  assign yIn     = res.y_in;
  assign trigger = res.valid_in && !valid_q;
  assign lastIdx = match_q ? 4'(MSG_LEN_MATCH - 1) : 4'(MSG_LEN_NONE - 1);
  assign busy_o  = (state_q != ST_IDLE);
  assign sent_o  = (state_q == ST_DONE);

  // State and datapath registers; valid_q tracks valid_in every cycle so held levels never retrigger.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      xBin_q  <= '0;
      yBin_q  <= '0;
      xBcd_q  <= '0;
      yBcd_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= res.valid_in;
      match_q <= match_d;
      xBin_q  <= xBin_d;
      yBin_q  <= yBin_d;
      xBcd_q  <= xBcd_d;
      yBcd_q  <= yBcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: capture, parallel double-dabble of x and y, then one byte per LOAD/WAIT pass.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    xBin_d  = xBin_q;
    yBin_d  = yBin_q;
    xBcd_d  = xBcd_q;
    yBcd_d  = yBcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    txStart = 1'b0;
    xAdj    = dd_adjust(xBcd_q);
    yAdj    = dd_adjust(yBcd_q);
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          match_d = res.match_in;
          xBin_d  = BIN_W'(xIn);
          yBin_d  = BIN_W'(yIn);
          xBcd_d  = '0;
          yBcd_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = res.match_in ? ST_CONVERT : ST_LOAD;
        end
      end
      ST_CONVERT: begin
        xBcd_d = {xAdj[BCD_W-2:0], xBin_q[BIN_W-1]};
        yBcd_d = {yAdj[BCD_W-2:0], yBin_q[BIN_W-1]};
        xBin_d = {xBin_q[BIN_W-2:0], 1'b0};
        yBin_d = {yBin_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == DD_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!txBusy) begin
          txStart = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (txDone) begin
          if (idx_q == lastIdx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pick the message byte at the current index.
  always_comb begin
    txByte = 8'h00;
    if (match_q) begin
      case (idx_q)
        4'd0:    txByte = ASCII_X;
        4'd1:    txByte = digit_char(xBcd_q[15:12]);
        4'd2:    txByte = digit_char(xBcd_q[11:8]);
        4'd3:    txByte = digit_char(xBcd_q[7:4]);
        4'd4:    txByte = digit_char(xBcd_q[3:0]);
        4'd5:    txByte = ASCII_COMMA;
        4'd6:    txByte = ASCII_Y;
        4'd7:    txByte = digit_char(yBcd_q[15:12]);
        4'd8:    txByte = digit_char(yBcd_q[11:8]);
        4'd9:    txByte = digit_char(yBcd_q[7:4]);
        4'd10:   txByte = digit_char(yBcd_q[3:0]);
        4'd11:   txByte = ASCII_CR;
        default: txByte = ASCII_LF;
      endcase
    end else begin
      case (idx_q)
        4'd0:    txByte = ASCII_N;
        4'd1:    txByte = ASCII_O;
        4'd2:    txByte = ASCII_N;
        4'd3:    txByte = ASCII_E;
        4'd4:    txByte = ASCII_CR;
        default: txByte = ASCII_LF;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) uTx (
    .clock (clock),
    .reset (reset),
    .start (txStart),
    .data  (txByte),
    .TxD   (TxD),
    .busy  (txBusy),
    .done  (txDone)
  );

endmodule

// File: tb/tb_result_uart_reporter.sv
// Bench for result_uart_reporter: drives matcher results, decodes the UART
// line with a monitor and compares each byte against a scoreboard queue.
module tb_result_uart_reporter;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } rx_item_t;

  logic clock;
  logic reset;
  logic TxD;
  logic busyO;
  logic sentO;

  int vecCount  = 0;
  int errCount  = 0;
  int rxCount   = 0;
  int sentCount = 0;

  rx_item_t expQ[$];

  result_uart_reporter_if #(.X_W(10), .Y_W(9)) resIf ();

  result_uart_reporter #(
    .BAUD_DIV (4),
    .X_W      (10),
    .Y_W      (9)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .res    (resIf),
    .TxD    (TxD),
    .busy_o (busyO),
    .sent_o (sentO)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count sent_o pulses away from the active edge.
  always @(negedge clock) if (sentO) sentCount++;

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushByte(input logic [7:0] b, input bit last);
    rx_item_t it;
    it.b    = b;
    it.last = last;
    expQ.push_back(it);
  endtask

  // Expected ASCII message for one result.
  task automatic pushMessage(input bit m, input int x, input int y);
    if (m) begin
      pushByte("X", 0);
      pushByte(8'h30 + 8'((x / 1000) % 10), 0);
      pushByte(8'h30 + 8'((x / 100) % 10), 0);
      pushByte(8'h30 + 8'((x / 10) % 10), 0);
      pushByte(8'h30 + 8'(x % 10), 0);
      pushByte(",", 0);
      pushByte("Y", 0);
      pushByte(8'h30 + 8'((y / 1000) % 10), 0);
      pushByte(8'h30 + 8'((y / 100) % 10), 0);
      pushByte(8'h30 + 8'((y / 10) % 10), 0);
      pushByte(8'h30 + 8'(y % 10), 0);
      pushByte(8'h0D, 0);
      pushByte(8'h0A, 1);
    end else begin
      pushByte("N", 0);
      pushByte("O", 0);
      pushByte("N", 0);
      pushByte("E", 0);
      pushByte(8'h0D, 0);
      pushByte(8'h0A, 1);
    end
  endtask

  // Raise valid with a new result and record the message it should produce.
  task automatic applyStimulus(input bit m, input int x, input int y);
    @(negedge clock);
    resIf.match_in = m;
    resIf.x_in     = 10'(x);
    resIf.y_in     = 9'(y);
    resIf.valid_in = 1'b1;
    pushMessage(m, x, y);
  endtask

  // Follow one report to sent_o, checking start latency, total length and the aftermath.
  task automatic waitReport(input bit m, input bit hold, input int pulseAt);
    int n;
    int startN;
    int nBytes;
    int sentBase;
    n        = 0;
    startN   = -1;
    nBytes   = m ? 13 : 6;
    sentBase = sentCount;
    while (n < 900) begin
      @(negedge clock);
      n++;
      if (!hold && n == 1) resIf.valid_in = 1'b0;
      if (n == pulseAt) begin
        resIf.valid_in = 1'b1;
        resIf.match_in = 1'b0;
        resIf.x_in     = 10'd999;
      end
      if (n == pulseAt + 1) resIf.valid_in = 1'b0;
      if (startN < 0 && TxD == 1'b0) startN = n;
      if (sentO) break;
    end
    checkOutput("sent_seen", sentO, 1'b1);
    checkOutput("start_latency_ok", (startN >= 1) && (startN <= (m ? 13 : 3)), 1'b1);
    checkOutput("sent_latency_ok",
                (n >= nBytes * 40 + 1) && (n <= (m ? 13 : 3) + nBytes * 40 + (nBytes - 1) * 2 + 2), 1'b1);
    @(negedge clock);
    checkOutput("busy_after_sent", busyO, 1'b0);
    #1;
    checkOutput("one_sent_pulse", sentCount - sentBase, 1);
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  // UART receiver: samples every cycle, checks 4-cycle bit cells, framing and inter-byte gaps.
  initial begin : rxMonitor
    logic [39:0] s;
    bit          pendingStart;
    bit          aborted;
    bit          frameOk;
    int          g;
    logic [7:0]  rxByte;
    rx_item_t    item;
    pendingStart = 0;
    forever begin
      if (!pendingStart) begin
        @(negedge clock);
        if (reset || TxD) continue;
      end
      pendingStart = 0;
      aborted      = 0;
      s            = '1;
      s[0]         = TxD;
      for (int i = 1; i < 40; i++) begin
        @(negedge clock);
        if (reset) begin
          aborted = 1;
          break;
        end
        s[i] = TxD;
      end
      if (aborted) continue;
      frameOk = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
      for (int k = 0; k < 10; k++) begin
        if (s[4*k +: 4] != 4'h0 && s[4*k +: 4] != 4'hF) frameOk = 0;
      end
      for (int i = 0; i < 8; i++) rxByte[i] = s[4*(i+1)];
      rxCount++;
      checkOutput("frame_bit_widths", frameOk, 1'b1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_byte", {24'h0, rxByte}, 32'h100);
      end else begin
        item = expQ.pop_front();
        checkOutput("rx_byte", {24'h0, rxByte}, {24'h0, item.b});
        if (!item.last) begin
          g = 0;
          for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (reset) begin
              aborted = 1;
              break;
            end
            if (!TxD) begin
              pendingStart = 1;
              break;
            end
            g++;
          end
          if (!aborted) checkOutput("inter_byte_gap", pendingStart && (g <= 2), 1'b1);
        end
      end
    end
  end

  // Test sequence.
  initial begin : mainSeq
    int base;
    int sentBase;
    int n;
    reset          = 1'b1;
    resIf.valid_in = 1'b0;
    resIf.match_in = 1'b0;
    resIf.x_in     = '0;
    resIf.y_in     = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_txd", TxD, 1'b1);
    checkOutput("reset_busy", busyO, 1'b0);
    checkOutput("reset_sent", sentO, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] basic match reports");
    applyStimulus(1'b1, 123, 45);
    waitReport(1'b1, 1'b0, -1);
    applyStimulus(1'b1, 1023, 511);
    waitReport(1'b1, 1'b0, -1);
    applyStimulus(1'b1, 0, 0);
    waitReport(1'b1, 1'b0, -1);

    $display("[TB] no-match report");
    applyStimulus(1'b0, 777, 300);
    waitReport(1'b0, 1'b0, -1);

    $display("[TB] valid held high");
    sentBase = sentCount;
    applyStimulus(1'b1, 500, 250);
    waitReport(1'b1, 1'b1, -1);
    repeat (1400) @(negedge clock);
    resIf.valid_in = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    checkOutput("held_valid_single_msg", sentCount - sentBase, 1);

    $display("[TB] rising edge while busy");
    sentBase = sentCount;
    applyStimulus(1'b1, 8, 9);
    waitReport(1'b1, 1'b0, 30);
    repeat (300) @(negedge clock);
    #1;
    checkOutput("busy_edge_ignored", sentCount - sentBase, 1);

    $display("[TB] reset during fifth byte");
    base     = rxCount;
    sentBase = sentCount;
    applyStimulus(1'b1, 42, 17);
    @(negedge clock);
    resIf.valid_in = 1'b0;
    n = 0;
    while (rxCount < base + 4 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bytes_before_abort", rxCount - base, 4);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    expQ.delete();
    @(negedge clock);
    checkOutput("abort_txd", TxD, 1'b1);
    checkOutput("abort_busy", busyO, 1'b0);
    checkOutput("abort_sent", sentO, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    #1;
    checkOutput("no_sent_after_abort", sentCount - sentBase, 0);
    checkOutput("no_rx_after_abort", rxCount - base, 4);

    $display("[TB] fresh report after reset");
    applyStimulus(1'b1, 314, 159);
    waitReport(1'b1, 1'b0, -1);

    repeat (10) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
